// File: rtl/bullet_arbiter.sv
// Enemy-tank bullet arbiter. Hands out up to four bullet slots to four tanks
// with round-robin fairness and a per-tank cooldown. Every grant shows up one
// cycle after it is decided.
module bullet_arbiter #(
    parameter int COOLDOWN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_4Hz,
    input  logic        game_en,
    input  logic [3:0]  tank_en,
    input  logic [3:0]  shoot_req,
    input  logic [19:0] tank_xpos,
    input  logic [19:0] tank_ypos,
    input  logic [7:0]  tank_dir,
    input  logic [3:0]  bul_done,
    output logic [3:0]  shoot_ack,
    output logic [3:0]  bul_load,
    output logic [19:0] bul_x,
    output logic [19:0] bul_y,
    output logic [7:0]  bul_dir,
    output logic [3:0]  slot_busy,
    output logic [7:0]  shot_cnt
);

    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN);

    logic [3:0] cd [4];
    logic [1:0] rr_ptr;

    logic [3:0] eligible;
    logic       grant_vld;
    logic [1:0] win;
    logic [1:0] slot;
    logic [3:0] grant_oh;
    logic [3:0] load_oh;

    // Shot counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A tank may win only if it is alive, cooled down, the game runs and a slot is free.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = shoot_req[i] & tank_en[i] & (cd[i] == 4'd0) & game_en & ~(&slot_busy);
        end
    end

    // Round-robin search from rr_ptr; walking backwards lets the closest candidate win last.
    always_comb begin
        logic [1:0] idx;
        grant_vld = 1'b0;
        win       = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                win       = idx;
            end
        end
    end

    // Lowest-index free slot; only meaningful when a grant is issued.
    always_comb begin
        slot = 2'd0;
        for (int s = 3; s >= 0; s--) begin
            if (!slot_busy[s]) slot = 2'(s);
        end
        grant_oh = grant_vld ? (4'b0001 << win)  : 4'b0000;
        load_oh  = grant_vld ? (4'b0001 << slot) : 4'b0000;
    end

    // Registered grant pulses and launch parameters of the loaded slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shoot_ack <= '0;
            bul_load  <= '0;
            bul_x     <= '0;
            bul_y     <= '0;
            bul_dir   <= '0;
        end else begin
            shoot_ack <= grant_oh;
            bul_load  <= load_oh;
            if (grant_vld) begin
                bul_x[int'(slot)*5 +: 5]   <= tank_xpos[int'(win)*5 +: 5];
                bul_y[int'(slot)*5 +: 5]   <= tank_ypos[int'(win)*5 +: 5];
                bul_dir[int'(slot)*2 +: 2] <= tank_dir[int'(win)*2 +: 2];
            end
        end
    end

    // Slot occupancy: done frees a slot next cycle, a load claims a free one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_busy <= '0;
        end else begin
            slot_busy <= (slot_busy & ~bul_done) | load_oh;
        end
    end

    // Per-tank cooldown: disabled tank clears, grant reloads, tick counts down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cd[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!tank_en[i])
                    cd[i] <= '0;
                else if (grant_oh[i])
                    cd[i] <= CD_LOAD;
                else if (tick_4Hz && cd[i] != 4'd0)
                    cd[i] <= cd[i] - 4'd1;
            end
        end
    end

    // Round-robin pointer moves past the winner; shot counter tracks every ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            shot_cnt <= '0;
        end else if (grant_vld) begin
            rr_ptr   <= win + 2'd1;
            shot_cnt <= sat_inc(shot_cnt);
        end
    end

endmodule

// File: tb/tb_bullet_arbiter.sv
// Directed bench for bullet_arbiter: one instance with COOLDOWN=2 for the
// slot/cooldown/gate/reset scenarios, one with COOLDOWN=0 for fairness and
// counter saturation.
module tb_bullet_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A (COOLDOWN=2)
    logic        a_tick, a_gen;
    logic [3:0]  a_en, a_req, a_done;
    logic [19:0] a_xi, a_yi;
    logic [7:0]  a_di;
    logic [3:0]  a_ack, a_load, a_busy;
    logic [19:0] a_bx, a_by;
    logic [7:0]  a_bd, a_cnt;

    // Instance B (COOLDOWN=0)
    logic        b_tick, b_gen;
    logic [3:0]  b_en, b_req, b_done;
    logic [19:0] b_xi, b_yi;
    logic [7:0]  b_di;
    logic [3:0]  b_ack, b_load, b_busy;
    logic [19:0] b_bx, b_by;
    logic [7:0]  b_bd, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bullet_arbiter #(.COOLDOWN(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_4Hz(a_tick), .game_en(a_gen),
        .tank_en(a_en), .shoot_req(a_req), .tank_xpos(a_xi), .tank_ypos(a_yi),
        .tank_dir(a_di), .bul_done(a_done), .shoot_ack(a_ack), .bul_load(a_load),
        .bul_x(a_bx), .bul_y(a_by), .bul_dir(a_bd), .slot_busy(a_busy),
        .shot_cnt(a_cnt)
    );

    bullet_arbiter #(.COOLDOWN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_4Hz(b_tick), .game_en(b_gen),
        .tank_en(b_en), .shoot_req(b_req), .tank_xpos(b_xi), .tank_ypos(b_yi),
        .tank_dir(b_di), .bul_done(b_done), .shoot_ack(b_ack), .bul_load(b_load),
        .bul_x(b_bx), .bul_y(b_by), .bul_dir(b_bd), .slot_busy(b_busy),
        .shot_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable for the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int err;
        logic [3:0] exp_ack;

        a_tick = 0; a_gen = 0; a_en = 0; a_req = 0; a_done = 0;
        a_xi = 0; a_yi = 0; a_di = 0;
        b_tick = 0; b_gen = 0; b_en = 0; b_req = 0; b_done = 0;
        b_xi = 0; b_yi = 0; b_di = 0;

        // Reset state
        #1;
        check("rst_ack",  a_ack,  4'h0);
        check("rst_busy", a_busy, 4'h0);
        check("rst_cnt",  a_cnt,  8'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single shot from tank 2
        a_en = 4'hF; a_gen = 1'b1;
        a_req = 4'b0100;
        a_xi[14:10] = 5'd5; a_yi[14:10] = 5'd9; a_di[5:4] = 2'd1;
        step();
        a_req = 4'b0000;
        check("ss_ack",  a_ack,      4'b0100);
        check("ss_load", a_load,     4'b0001);
        check("ss_x",    a_bx[4:0],  5'd5);
        check("ss_y",    a_by[4:0],  5'd9);
        check("ss_dir",  a_bd[1:0],  2'd1);
        check("ss_busy", a_busy,     4'b0001);
        check("ss_cnt",  a_cnt,      8'd1);

        // Fill the slots: pointer is 3, so tank 3 then tank 0
        a_req = 4'b1001;
        step();
        check("fill1_ack",  a_ack,  4'b1000);
        check("fill1_load", a_load, 4'b0010);
        check("fill1_busy", a_busy, 4'b0011);
        step();
        a_req = 4'b0000;
        check("fill2_ack",  a_ack,  4'b0001);
        check("fill2_load", a_load, 4'b0100);
        check("fill2_busy", a_busy, 4'b0111);
        // two ticks cool everybody down
        a_tick = 1'b1;
        step();
        step();
        a_tick = 1'b0;
        a_req = 4'b0100;
        step();
        check("fill3_ack",  a_ack,  4'b0100);
        check("fill3_busy", a_busy, 4'b1111);

        // Full: tank 1 must wait until a slot frees
        a_req = 4'b0010;
        a_xi[9:5] = 5'd7;
        step();
        check("full_ack0", a_ack, 4'b0000);
        step();
        check("full_ack1",  a_ack,  4'b0000);
        check("full_busy1", a_busy, 4'b1111);
        a_done = 4'b0100;
        step();
        a_done = 4'b0000;
        check("free_ack",  a_ack,  4'b0000);
        check("free_busy", a_busy, 4'b1011);
        step();
        a_req = 4'b0000;
        check("late_ack",  a_ack,        4'b0010);
        check("late_load", a_load,       4'b0100);
        check("late_busy", a_busy,       4'b1111);
        check("late_x",    a_bx[14:10],  5'd7);
        check("late_cnt",  a_cnt,        8'd5);

        // Game gate: no grants while disabled, busy only changes by done
        a_gen = 1'b0; a_req = 4'b0001; a_done = 4'b0011;
        step();
        a_done = 4'b0000;
        check("gate_ack0",  a_ack,  4'b0000);
        check("gate_busy0", a_busy, 4'b1100);
        step();
        step();
        check("gate_ack2",  a_ack,  4'b0000);
        check("gate_busy2", a_busy, 4'b1100);
        a_gen = 1'b1;
        step();
        check("ungate_ack",  a_ack,  4'b0001);
        check("ungate_load", a_load, 4'b0001);
        check("ungate_busy", a_busy, 4'b1101);

        // Cooldown: tank 0 keeps requesting, needs 2 ticks then one cycle
        step();
        check("cd_ack0", a_ack, 4'b0000);
        step();
        check("cd_ack1", a_ack, 4'b0000);
        a_tick = 1'b1;
        step();
        check("cd_ack2", a_ack, 4'b0000);
        step();
        check("cd_ack3", a_ack, 4'b0000);
        a_tick = 1'b0;
        step();
        check("cd_ack4",  a_ack,  4'b0001);
        check("cd_load4", a_load, 4'b0010);
        check("cd_busy4", a_busy, 4'b1111);
        // one tick leaves cd[0]=1, then disabling the tank clears it
        a_tick = 1'b1;
        step();
        check("cd_ack5", a_ack, 4'b0000);
        a_tick = 1'b0; a_en = 4'b1110; a_done = 4'hF;
        step();
        check("dis_ack",  a_ack,  4'b0000);
        check("dis_busy", a_busy, 4'b0000);
        a_en = 4'hF; a_done = 4'h0;
        step();
        check("reen_ack",  a_ack,  4'b0001);
        check("reen_busy", a_busy, 4'b0001);

        // Three slots busy, then asynchronous reset
        a_req = 4'b0110;
        step();
        check("r3_ack1", a_ack, 4'b0010);
        step();
        a_req = 4'b0000;
        check("r3_ack2",  a_ack,  4'b0100);
        check("r3_busy",  a_busy, 4'b0111);
        check("r3_cnt",   a_cnt,  8'd10);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", a_busy, 4'b0000);
        check("arst_cnt",  a_cnt,  8'd0);
        check("arst_x",    a_bx,   20'h0);
        step();
        rst_n = 1'b1;

        // First grant after reset searches from tank 0
        a_req = 4'hF;
        step();
        a_req = 4'h0;
        check("post_rst_ack", a_ack, 4'b0001);
        check("post_rst_cnt", a_cnt, 8'd1);

        // Fairness with COOLDOWN=0, every slot freed each cycle
        b_en = 4'hF; b_gen = 1'b1; b_req = 4'hF; b_done = 4'hF;
        step();
        check("rr_g0", b_ack, 4'b0001);
        step();
        check("rr_g1", b_ack, 4'b0010);
        step();
        check("rr_g2", b_ack, 4'b0100);
        step();
        check("rr_g3", b_ack, 4'b1000);
        step();
        check("rr_g4", b_ack, 4'b0001);
        check("rr_cnt5", b_cnt, 8'd5);

        // Saturation: keep granting every cycle, rotation must stay exact
        err = 0;
        for (int g = 5; g < 254; g++) begin
            step();
            exp_ack = 4'b0001 << (g % 4);
            if (b_ack !== exp_ack) err++;
        end
        check("sat_254", b_cnt, 8'd254);
        step();
        check("sat_255", b_cnt, 8'd255);
        for (int g = 255; g < 305; g++) begin
            step();
            exp_ack = 4'b0001 << (g % 4);
            if (b_ack !== exp_ack) err++;
        end
        check("sat_hold", b_cnt, 8'd255);
        check("rr_rotation_errors", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bullet_arbiter.md
BULLET_ARBITER -- requirements
Module: bullet_arbiter

Interface
REQ-001 Parameter COOLDOWN, default 4: number of tick_4Hz ticks a tank must wait after a granted shot before it may shoot again; legal range 0-15.
REQ-002 clk  in  1  system clock; every register in the block is clocked on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 tick_4Hz  in  1  single-clk-cycle pulse at 4 Hz; steps the cooldown counters.
REQ-005 game_en  in  1  1 = grants allowed; 0 = grants suspended.
REQ-006 tank_en  in  4  per enemy tank: tank alive/enabled.
REQ-007 shoot_req  in  4  per enemy tank: shot request, held until acked.
REQ-008 tank_xpos  in  20  tank i relative x at bits [5i+4:5i].
REQ-009 tank_ypos  in  20  tank i relative y at bits [5i+4:5i].
REQ-010 tank_dir  in  8  tank i direction at bits [2i+1:2i].
REQ-011 bul_done  in  4  per bullet slot: 1-cycle pulse when the bullet leaves the field or hits a target.
REQ-012 shoot_ack  out  4  per tank: 1-cycle grant pulse.
REQ-013 bul_load  out  4  per slot: 1-cycle load pulse.
REQ-014 bul_x  out  20  launch x per slot, same packing as tank_xpos.
REQ-015 bul_y  out  20  launch y per slot, same packing as tank_ypos.
REQ-016 bul_dir  out  8  launch direction per slot.
REQ-017 slot_busy  out  4  per slot: 1 = bullet in flight.
REQ-018 shot_cnt  out  8  total granted shots, saturating.

Function
REQ-019 Eligibility: tank i is eligible in cycle N iff shoot_req[i] & tank_en[i] & (cd[i]==0) & game_en all hold, and at least one slot_busy bit is 0.
REQ-020 At most one grant is issued per cycle; the winner is the first eligible tank found by a round-robin search starting at pointer rr_ptr (2 bits) and proceeding rr_ptr, rr_ptr+1, ... mod 4.
REQ-021 The granted slot s is the lowest-index slot with slot_busy==0, sampled in cycle N.
REQ-022 A grant decided in cycle N produces, in cycle N+1: shoot_ack[i]=1, bul_load[s]=1, slot_busy[s]=1, and the bul_x/bul_y/bul_dir fields for slot s loaded with tank i's values as sampled in cycle N. Latency is 1 cycle.
REQ-023 The bul_x/bul_y/bul_dir fields of a slot hold their values until that slot's next load.
REQ-024 On a grant, rr_ptr becomes (i+1) mod 4; with no grant, rr_ptr holds.
REQ-025 On a grant, cd[i] (4 bits) loads COOLDOWN; on each tick_4Hz, every nonzero cd decrements by 1; if a grant and a tick coincide for the same tank, the load wins.
REQ-026 tank_en[i]==0 clears cd[i] to 0 and masks shoot_req[i].
REQ-027 bul_done[s] with slot_busy[s]=1 clears slot_busy[s] in the next cycle; a freed slot becomes grantable only from the cycle after it is cleared (no same-cycle bypass).
REQ-028 bul_done[s] on a slot that is already free is ignored.
REQ-029 A load and a done can never target the same slot in the same cycle, because loads target only free slots.
REQ-030 When all four slots are busy, no grant is issued and requests stay pending without an ack.
REQ-031 A request dropped before its ack is simply not granted; no state changes.
REQ-032 game_en==0 blocks new grants only; in-flight bullets keep their busy state and cooldowns keep counting.
REQ-033 shot_cnt increments by 1 in the same cycle as each shoot_ack and saturates at 255.
REQ-034 shoot_ack and bul_load are each one-hot or all-zero, and are never asserted for two consecutive cycles for the same tank unless COOLDOWN==0.

Reset
REQ-035 While rst_n==0, all of the following are 0, immediately and asynchronously: shoot_ack, bul_load, bul_x, bul_y, bul_dir, slot_busy, shot_cnt, all cd counters, and rr_ptr.
REQ-036 Reset asserted mid-operation aborts any pending grant and frees all slots.
REQ-037 The first eligible cycle after rst_n rises grants normally, with the round-robin search starting at tank 0.

Verification
REQ-038 Single shot: reset, then tank 2 requests at x=5, y=9, dir=1 -> the next cycle shows shoot_ack=0100, bul_load=0001, bul_x[4:0]=5, bul_y[4:0]=9, bul_dir[1:0]=1, slot_busy=0001, shot_cnt=1.
REQ-039 Fairness: all 4 tanks request continuously with COOLDOWN=0 and bul_done pulsed each cycle -> grant order is 0, 1, 2, 3, 0, and each tank receives exactly 1 ack per 4 grants.
REQ-040 Full: 4 slots are busy and tank 1 requests -> no ack; pulse bul_done[2] -> slot 2 clears one cycle later, and tank 1's grant lands on slot 2 in the cycle after that.
REQ-041 Cooldown: COOLDOWN=2 and tank 0 holds its request -> a second ack only after 2 tick_4Hz pulses and then 1 more cycle; dropping tank_en[0] mid-cooldown clears cd[0].
REQ-042 Gate and reset: game_en=0 with requests pending -> no acks and slot_busy unchanged; asserting rst_n=0 while 3 slots are busy -> slot_busy=0000 and shot_cnt=0 immediately.
REQ-043 Saturation: 300 grants -> shot_cnt stops at 255.
